// File: rtl/cordic_alg_block.sv
// One registered micro-rotation stage of a rotation-mode CORDIC; chain stages with ITER = 0..N-1.
// Optional build macro: CORDIC_SAT_EN (saturate X/Y on overflow instead of wrapping).
module cordic_alg_block #(
  parameter int DATA_WIDTH = 20,
  parameter int PHI_WIDTH  = 19,
  parameter int ITER       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         data_in,
  input  logic signed [DATA_WIDTH-1:0] X_in,
  input  logic signed [DATA_WIDTH-1:0] Y_in,
  input  logic        [PHI_WIDTH-1:0]  phi_veer_in,
  output logic signed [DATA_WIDTH-1:0] X_out,
  output logic signed [DATA_WIDTH-1:0] Y_out,
  output logic        [PHI_WIDTH-1:0]  phi_veer_out,
  output logic                         done
);

  // atan(2^-i) in degrees, Q.12, fixed at elaboration
  function automatic int unsigned atan_const(input int iter);
    case (iter)
      0:       atan_const = 32'd184320;
      1:       atan_const = 32'd108810;
      2:       atan_const = 32'd57492;
      3:       atan_const = 32'd29184;
      4:       atan_const = 32'd14649;
      5:       atan_const = 32'd7331;
      6:       atan_const = 32'd3667;
      7:       atan_const = 32'd1833;
      8:       atan_const = 32'd917;
      9:       atan_const = 32'd458;
      10:      atan_const = 32'd229;
      11:      atan_const = 32'd115;
      12:      atan_const = 32'd57;
      13:      atan_const = 32'd29;
      14:      atan_const = 32'd14;
      15:      atan_const = 32'd7;
      default: atan_const = 32'd0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_fit(input logic [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat_fit = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat_fit = s[DATA_WIDTH-1:0];
    end
  endfunction

  localparam int unsigned          ATAN_A = atan_const(ITER);
  localparam logic [PHI_WIDTH:0]   A_EXT  = (PHI_WIDTH+1)'(ATAN_A);

  logic signed [DATA_WIDTH-1:0] x_sh_s, y_sh_s;
  logic        [DATA_WIDTH:0]   x_ext_s, y_ext_s, xs_ext_s, ys_ext_s, x_sum_s, y_sum_s;
  logic        [PHI_WIDTH:0]    mag_ext_s, phi_tc_s, phi_abs_s;
  logic                         cw_s;
  logic signed [DATA_WIDTH-1:0] x_d, y_d, x_q, y_q;
  logic        [PHI_WIDTH-1:0]  phi_d, phi_q;
  logic                         done_d, done_q;

  // -0 has a zero magnitude and therefore rotates counter-clockwise like +0
  always_comb begin
    x_sh_s    = X_in >>> ITER;
    y_sh_s    = Y_in >>> ITER;
    x_ext_s   = {X_in[DATA_WIDTH-1], X_in};
    y_ext_s   = {Y_in[DATA_WIDTH-1], Y_in};
    xs_ext_s  = {x_sh_s[DATA_WIDTH-1], x_sh_s};
    ys_ext_s  = {y_sh_s[DATA_WIDTH-1], y_sh_s};
    mag_ext_s = {2'b00, phi_veer_in[PHI_WIDTH-2:0]};
    cw_s      = phi_veer_in[PHI_WIDTH-1] & (|phi_veer_in[PHI_WIDTH-2:0]);
    if (cw_s) begin
      x_sum_s  = x_ext_s + ys_ext_s;
      y_sum_s  = y_ext_s - xs_ext_s;
      phi_tc_s = A_EXT - mag_ext_s;
    end else begin
      x_sum_s  = x_ext_s - ys_ext_s;
      y_sum_s  = y_ext_s + xs_ext_s;
      phi_tc_s = mag_ext_s - A_EXT;
    end
    if (phi_tc_s[PHI_WIDTH]) begin
      phi_abs_s = -phi_tc_s;
    end else begin
      phi_abs_s = phi_tc_s;
    end
    // sign comes from the two's-complement result, so a zero result is always +0
    phi_d  = {phi_tc_s[PHI_WIDTH], phi_abs_s[PHI_WIDTH-2:0]};
    done_d = data_in;
`ifdef CORDIC_SAT_EN
    x_d = sat_fit(x_sum_s);
    y_d = sat_fit(y_sum_s);
`else
    x_d = x_sum_s[DATA_WIDTH-1:0];
    y_d = y_sum_s[DATA_WIDTH-1:0];
`endif
  end

`ifndef CORDIC_SAT_EN
  logic unused_carry_s;
  assign unused_carry_s = x_sum_s[DATA_WIDTH] ^ y_sum_s[DATA_WIDTH];
`endif
  logic unused_phi_s;
  assign unused_phi_s = ^phi_abs_s[PHI_WIDTH:PHI_WIDTH-1];

  // Output registers; enable low holds every register, done included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      phi_q  <= '0;
      done_q <= 1'b0;
    end else if (enable) begin
      x_q    <= x_d;
      y_q    <= y_d;
      phi_q  <= phi_d;
      done_q <= done_d;
    end
  end

  assign X_out        = x_q;
  assign Y_out        = y_q;
  assign phi_veer_out = phi_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cordic_alg_block.sv
// Randomized bench for cordic_alg_block: three stages (ITER 0, 1, 13) against an integer reference model.
module tb_cordic_alg_block;
  localparam int NI = 3;
  localparam int ITERS [NI] = '{0, 1, 13};
  localparam int ATAN [16] = '{184320, 108810, 57492, 29184, 14649, 7331, 3667, 1833,
                               917, 458, 229, 115, 57, 29, 14, 7};

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, data_in = 1'b0;
  logic [19:0] x_in = '0, y_in = '0;
  logic [18:0] phi_in = '0;
  logic [19:0] x_o [NI];
  logic [19:0] y_o [NI];
  logic [18:0] p_o [NI];
  logic        d_o [NI];
  logic [19:0] e_x [NI];
  logic [19:0] e_y [NI];
  logic [18:0] e_p [NI];
  logic        e_d;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cordic_alg_block #(.DATA_WIDTH(20), .PHI_WIDTH(19), .ITER(ITERS[g])) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .X_in(x_in), .Y_in(y_in), .phi_veer_in(phi_in),
      .X_out(x_o[g]), .Y_out(y_o[g]), .phi_veer_out(p_o[g]), .done(d_o[g]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] fit(input int v);
`ifdef CORDIC_SAT_EN
    if (v > 524287) v = 524287;
    if (v < -524288) v = -524288;
`endif
    return v[19:0];
  endfunction

  // Rotation by +/-atan(2^-i), with the angle as a signed integer count of 1/4096 degree
  task automatic model(input int iter, input logic [19:0] x, input logic [19:0] y, input logic [18:0] phi,
                       output logic [19:0] xo, output logic [19:0] yo, output logic [18:0] po);
    int xi, yi, xs, ys, ph, np;
    xi = $signed(x);
    yi = $signed(y);
    xs = xi >>> iter;
    ys = yi >>> iter;
    ph = int'(phi[17:0]);
    if (phi[18]) ph = -ph;
    if (ph < 0) begin
      xo = fit(xi + ys); yo = fit(yi - xs); np = ph + ATAN[iter];
    end else begin
      xo = fit(xi - ys); yo = fit(yi + xs); np = ph - ATAN[iter];
    end
    po = (np < 0) ? {1'b1, 18'(-np)} : {1'b0, 18'(np)};
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(x_o[k]), 32'(e_x[k]));
      check($sformatf("%s_y%0d", tag, k), 32'(y_o[k]), 32'(e_y[k]));
      check($sformatf("%s_phi%0d", tag, k), 32'(p_o[k]), 32'(e_p[k]));
      check($sformatf("%s_done%0d", tag, k), 32'(d_o[k]), 32'(e_d));
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NI; k++) begin
      e_x[k] = '0; e_y[k] = '0; e_p[k] = '0;
    end
    e_d = 1'b0;
  endtask

  task automatic step(input string tag, input logic en, input logic dv,
                      input logic [19:0] x, input logic [19:0] y, input logic [18:0] phi);
    @(negedge clk);
    enable = en; data_in = dv; x_in = x; y_in = y; phi_in = phi;
    @(posedge clk);
    #1;
    if (en) begin
      for (int k = 0; k < NI; k++) model(ITERS[k], x, y, phi, e_x[k], e_y[k], e_p[k]);
      e_d = dv;
    end
    check_all(tag);
  endtask

  initial begin
    logic [19:0] rx, ry;
    logic [18:0] rp;
    clear_exp();
    #3;
    check_all("reset_noclk");
    @(negedge clk);
    rst = 1'b0;
    step("idle", 1'b1, 1'b0, 20'h00000, 20'h00000, 19'h00000);
    check("idle_done", 32'(d_o[0]), 32'd0);

    step("tp_m55", 1'b1, 1'b1, 20'h01000, 20'h00000, 19'b1110111000000000000);
    check("tp_m55_x", 32'(x_o[0]), 32'h01000);
    check("tp_m55_y", 32'(y_o[0]), 32'hFF000);
    check("tp_m55_phi", 32'(p_o[0]), 32'(19'b1001010000000000000));
    check("tp_m55_done", 32'(d_o[0]), 32'd1);

    step("tp_p55", 1'b1, 1'b1, 20'h0A000, 20'h00000, 19'h37000);
    check("tp_p55_y", 32'(y_o[0]), 32'h0A000);
    check("tp_p55_phi", 32'(p_o[0]), 32'(19'b0001010000000000000));

    step("tp_p10", 1'b1, 1'b1, 20'h0A000, 20'h0A000, 19'h0A000);
    check("tp_p10_x", 32'(x_o[0]), 32'h00000);
    check("tp_p10_y", 32'(y_o[0]), 32'h14000);
    check("tp_p10_phi", 32'(p_o[0]), 32'(19'h40000 | 19'h23000));

    step("tp_i1_p0", 1'b1, 1'b1, 20'h08000, 20'h04000, 19'h00000);
    check("tp_i1_p0_x", 32'(x_o[1]), 32'h06000);
    check("tp_i1_p0_y", 32'(y_o[1]), 32'h08000);
    check("tp_i1_p0_phi", 32'(p_o[1]), 32'({1'b1, 18'd108810}));
    step("tp_i1_m0", 1'b1, 1'b0, 20'h08000, 20'h04000, 19'h40000);
    check("tp_i1_m0_x", 32'(x_o[1]), 32'h06000);
    check("tp_i1_m0_phi", 32'(p_o[1]), 32'({1'b1, 18'd108810}));

    step("ovf", 1'b1, 1'b1, 20'h7F000, 20'h7F000, 19'h01000);
`ifdef CORDIC_SAT_EN
    check("ovf_y", 32'(y_o[0]), 32'h7FFFF);
`else
    check("ovf_y", 32'(y_o[0]), 32'hFE000);
`endif

    step("hold0", 1'b0, 1'b0, 20'h12345, 20'h54321, 19'h12345);
    step("hold1", 1'b0, 1'b1, 20'h00001, 20'hFFFFF, 19'h7FFFF);
    step("hold2", 1'b0, 1'b0, 20'h80000, 20'h7FFFF, 19'h40001);
    check("hold_done", 32'(d_o[0]), 32'd1);

    for (int i = 0; i < 300; i++) begin
      rx = 20'($urandom);
      ry = 20'($urandom);
      case ($urandom_range(0, 7))
        0:       rp = 19'h00000;
        1:       rp = 19'h40000;
        2:       rp = 19'h7FFFF;
        3:       rp = 19'h3FFFF;
        default: rp = 19'($urandom);
      endcase
      step("rand", 1'($urandom_range(0, 9) != 0), 1'($urandom), rx, ry, rp);
    end

    @(negedge clk);
    rst = 1'b1;
    #1;
    clear_exp();
    check_all("reset_mid");
    #1;
    rst = 1'b0;
    step("post_reset", 1'b1, 1'b1, 20'h03000, 20'hFD000, 19'h5A000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cordic_alg_block.md
Name: cordic_alg_block

Overview:
- One pipelined micro-rotation stage of a CORDIC rotation-mode engine. Stage index is set by parameter ITER.
- A full rotator is built by chaining N instances with ITER = 0..N-1; the X/Y/angle outputs of one stage feed the next.
- Each stage rotates the vector by ±atan(2^-ITER) degrees toward driving the residual angle to zero.
- The output is registered, with a one-cycle valid handshake.

Parameters:
- DATA_WIDTH, 20: width of X/Y. Two's complement, Q8.12 (bit 19 is the sign, [18:12] integer, [11:0] fraction).
- PHI_WIDTH, 19: width of the angle in degrees. Sign-magnitude: bit 18 is the sign (1 = negative), [17:12] integer magnitude, [11:0] fraction.
- ITER, 0: stage index i, legal range 0..15. Selects the shift amount and the atan constant.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  clock enable; when low, all registers hold.
- data_in  input  1  input-valid qualifier.
- X_in  input  DATA_WIDTH  signed X coordinate.
- Y_in  input  DATA_WIDTH  signed Y coordinate.
- phi_veer_in  input  PHI_WIDTH  residual angle, sign-magnitude degrees.
- X_out  output  DATA_WIDTH  rotated X, registered.
- Y_out  output  DATA_WIDTH  rotated Y, registered.
- phi_veer_out  output  PHI_WIDTH  updated residual angle, sign-magnitude, registered.
- done  output  1  output-valid; registered copy of data_in.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset state: X_out = 0, Y_out = 0, phi_veer_out = 0, done = 0. Reset asserted mid-operation clears everything immediately, with no clock required.
- Latency: exactly 1 clock. Registers update on each rising clk edge where enable = 1.
- done follows data_in with one cycle of delay.
- The X/Y/phi registers load on every enabled edge, regardless of data_in. Downstream logic must qualify the data with done.
- enable = 0 freezes all outputs, including done.
- Direction select uses d = phi_veer_in[PHI_WIDTH-1]:
  - d = 0 (angle ≥ 0, including +0 and -0 when the magnitude is 0): counter-clockwise.
    - X_out = X_in - (Y_in >>> ITER)
    - Y_out = Y_in + (X_in >>> ITER)
    - phi = phi - A
  - d = 1 with nonzero magnitude: clockwise.
    - X_out = X_in + (Y_in >>> ITER)
    - Y_out = Y_in - (X_in >>> ITER)
    - phi = phi + A
- Shifts are arithmetic, sign-preserving and truncating. X/Y sums wrap modulo 2^DATA_WIDTH unless CORDIC_SAT_EN is defined.
- The stage applies no gain compensation; the 1.6468 CORDIC gain is handled outside this block.
- Angle arithmetic:
  - Convert sign-magnitude to PHI_WIDTH+1-bit two's complement, add/subtract A, then convert back.
  - A negative result gives sign = 1 and magnitude = |result|. A zero result is always emitted as +0.
  - If the magnitude exceeds 2^(PHI_WIDTH-1)-1, it is truncated to the low PHI_WIDTH-1 bits.
- A = round(atan(2^-ITER)·180/π·4096). Values for ITER 0..15: 184320, 108810, 57492, 29184, 14649, 7331, 3667, 1833, 917, 458, 229, 115, 57, 29, 14, 7.
- ITER > 15 gives A = 0.
- A is a constant selected at elaboration; there is no runtime table lookup.

Optional Feature:
- Macro: CORDIC_SAT_EN.
- When defined: X_out and Y_out saturate to the most-positive or most-negative DATA_WIDTH value on signed overflow of the add/subtract.
- When undefined: plain two's-complement wrap-around.
- The angle path and timing are identical in both builds.

Test Plan:
- Reset: assert rst with no clock → all outputs 0, done = 0. Deassert rst, with enable = 1 and data_in = 0, one edge → done stays 0.
- ITER = 0, X_in = 1.0 (0x01000), Y_in = 0, phi = -55 (19'b1110111000000000000), data_in = 1, one edge → done = 1, X_out = 0x01000, Y_out = 0xFF000 (-1.0), phi_veer_out = -10 (19'b1001010000000000000).
- ITER = 0, X = 10, Y = 0, phi = +55 → X_out = 10, Y_out = 10, phi_veer_out = +10 (19'b0001010000000000000).
- ITER = 0, X = 10, Y = 10, phi = +10 → X_out = 0, Y_out = 20, phi_veer_out = -35 (sign 1, magnitude 35.0).
- ITER = 1, X = 8, Y = 4, phi = 0 (counter-clockwise) → X_out = 6, Y_out = 8, phi_veer_out = -108810/4096 (sign 1, magnitude 108810). Repeat with phi = -0 → same result.
- Enable hold: load any vector, then drop enable and toggle data_in for 3 edges → all outputs and done unchanged. With CORDIC_SAT_EN: X = 0x7F000, Y = 0x7F000, ITER = 0, phi = +1 → Y_out saturates to 0x7FFFF.
